// File: rtl/reg8_arb_pkg.sv
// rtl/reg8_arb_pkg.sv - shared types and index helpers for the reg8 write arbiter
// Purpose: FSM state encoding, default data width, round-robin index helpers.
// Ports: none (package).
package reg8_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 8;

  // Next requester index after idx, wrapping at n (n need not be a power of two).
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Bit pos of the one-hot encoding of idx.
  function automatic logic onehot_bit(input int idx, input int pos);
    return idx == pos;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Purpose: first set req scanning upward from rr_ptr with wrap at NUM_REQ.
// Ports:
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  IDX_W    highest-priority index this round
//   winner  out IDX_W    chosen index (0 when no request)
//   any_req out 1        at least one request present
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  always_comb begin
    int j;
    j       = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_req && req[j]) begin
        any_req = 1'b1;
        winner  = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/reg8_wr_arbiter.sv
// rtl/reg8_wr_arbiter.sv - round-robin write-port arbiter for an 8-bit holding register
// Purpose: shares the register write port among NUM_REQ requesters with
//          req/gnt handshake, dst_rdy back-pressure and bounded burst lock.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req, lock   per-requester request and keep-grant wish
//   din         flattened data, requester i at [i*DATA_W +: DATA_W]
//   dst_rdy     downstream accepts a write this cycle
//   gnt         registered one-hot grant
//   ack         registered one-cycle pulse to the written requester
//   dout        registered written data, held between transfers
//   dout_vld    registered one-cycle pulse, dout is new
module reg8_wr_arbiter
  import reg8_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  input  logic                      dst_rdy,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_vld
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int LCNT_W = $clog2(LOCK_MAX + 1);

  state_t              state, state_n;
  logic [IDX_W-1:0]    winner, winner_n;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_n;
  logic [LCNT_W-1:0]   lock_cnt, lock_cnt_n;
  logic [NUM_REQ-1:0]  gnt_n, ack_n;
  logic [DATA_W-1:0]   dout_n;
  logic                dout_vld_n;
  logic [IDX_W-1:0]    pick;
  logic                any_req;
  logic [NUM_REQ-1:0]  oh_pick, oh_win;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (pick),
    .any_req (any_req)
  );

  always_comb begin
    oh_pick = '0;
    oh_win  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      oh_pick[i] = onehot_bit(int'(pick), i);
      oh_win[i]  = onehot_bit(int'(winner), i);
    end
  end

  always_comb begin
    state_n    = state;
    winner_n   = winner;
    rr_ptr_n   = rr_ptr;
    lock_cnt_n = lock_cnt;
    gnt_n      = gnt;
    ack_n      = '0;
    dout_n     = dout;
    dout_vld_n = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n  = GRANT;
          winner_n = pick;
          gnt_n    = oh_pick;
        end
      end
      GRANT: begin
        if (!req[winner]) begin
          // Abandon: release without touching data or fairness pointer.
          state_n    = IDLE;
          gnt_n      = '0;
          lock_cnt_n = '0;
        end else if (dst_rdy) begin
          dout_n     = din[int'(winner)*DATA_W +: DATA_W];
          dout_vld_n = 1'b1;
          ack_n      = oh_win;
          rr_ptr_n   = IDX_W'(next_idx(int'(winner), NUM_REQ));
          // Locked winner keeps the grant until LOCK_MAX writes, then must re-arbitrate.
          if (lock[winner] && (lock_cnt < LCNT_W'(LOCK_MAX - 1))) begin
            lock_cnt_n = lock_cnt + 1'b1;
          end else begin
            lock_cnt_n = '0;
            gnt_n      = '0;
            state_n    = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      winner   <= '0;
      rr_ptr   <= '0;
      lock_cnt <= '0;
      gnt      <= '0;
      ack      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      state    <= state_n;
      winner   <= winner_n;
      rr_ptr   <= rr_ptr_n;
      lock_cnt <= lock_cnt_n;
      gnt      <= gnt_n;
      ack      <= ack_n;
      dout     <= dout_n;
      dout_vld <= dout_vld_n;
    end
  end

endmodule
